// File: rtl/fp_pkg.sv
// Shared floating-point types and constants for the FP compare datapath.
// Widths are passed as arguments so one package serves every format.
package fp_pkg;

  typedef enum logic [2:0] {
    ZERO,
    SUB,
    NORM,
    INF,
    QNAN,
    SNAN
  } fp_class_e;

  // Canonical quiet NaN, right-aligned in 64 bits; callers cast to their word width.
  function automatic logic [63:0] canon_qnan(input int unsigned exp_w, input int unsigned man_w);
    logic [63:0] r;
    r = (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
    return r;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 operand classifier: returns class and sign of one word.
module fp_classify
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] x,
  output fp_class_e            cls,
  output logic                 sign
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;

  assign sign  = x[EXP_W+MAN_W];
  assign exp_f = x[EXP_W+MAN_W-1:MAN_W];
  assign man_f = x[MAN_W-1:0];

  always_comb begin
    cls = NORM;
    if (exp_f == '0) begin
      cls = (man_f == '0) ? ZERO : SUB;
    end else if (exp_f == '1) begin
      if (man_f == '0) begin
        cls = INF;
      end else if (man_f[MAN_W-1]) begin
        cls = QNAN;
      end else begin
        cls = SNAN;
      end
    end
  end

endmodule

// File: rtl/fp_cmp_pipe.sv
// Two-stage elastic IEEE-754 comparator with quiet/signaling modes and invalid flag.
// Define FP_CMP_MINMAX_EN to add the minimumNumber/maximumNumber result ports.
module fp_cmp_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 signaling,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 lt,
  output logic                 eq,
  output logic                 gt,
  output logic                 unord,
  output logic                 invalid
`ifdef FP_CMP_MINMAX_EN
  ,
  output logic [EXP_W+MAN_W:0] min_res,
  output logic [EXP_W+MAN_W:0] max_res
`endif
);

  localparam int unsigned W = 1 + EXP_W + MAN_W;

  fp_class_e cls_a, cls_b;
  logic      sign_a, sign_b;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (.x(a), .cls(cls_a), .sign(sign_a));
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (.x(b), .cls(cls_b), .sign(sign_b));

  logic s1_valid_q, s2_valid_q;
  logic s1_load, s2_load;

  assign s2_load   = !s2_valid_q || out_ready;
  assign s1_load   = !s1_valid_q || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid_q;

  // Stage 1: classification, signs and unsigned magnitude compare.
  fp_class_e cls_a_q, cls_b_q;
  logic      sign_a_q, sign_b_q, mag_lt_q, mag_eq_q, sig_q;
`ifdef FP_CMP_MINMAX_EN
  logic [W-1:0] a_q, b_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      cls_a_q    <= ZERO;
      cls_b_q    <= ZERO;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      mag_lt_q   <= 1'b0;
      mag_eq_q   <= 1'b0;
      sig_q      <= 1'b0;
`ifdef FP_CMP_MINMAX_EN
      a_q        <= '0;
      b_q        <= '0;
`endif
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      cls_a_q    <= cls_a;
      cls_b_q    <= cls_b;
      sign_a_q   <= sign_a;
      sign_b_q   <= sign_b;
      mag_lt_q   <= a[W-2:0] < b[W-2:0];
      mag_eq_q   <= a[W-2:0] == b[W-2:0];
      sig_q      <= signaling;
`ifdef FP_CMP_MINMAX_EN
      a_q        <= a;
      b_q        <= b;
`endif
    end
  end

  // Stage 2 next-state: relation flags and exception.
  logic a_nan, b_nan, both_zero;
  logic lt_d, eq_d, gt_d, unord_d, invalid_d;

  always_comb begin
    a_nan     = (cls_a_q == QNAN) || (cls_a_q == SNAN);
    b_nan     = (cls_b_q == QNAN) || (cls_b_q == SNAN);
    both_zero = (cls_a_q == ZERO) && (cls_b_q == ZERO);
    unord_d   = a_nan || b_nan;
    invalid_d = (cls_a_q == SNAN) || (cls_b_q == SNAN) || (sig_q && unord_d);
    lt_d      = 1'b0;
    eq_d      = 1'b0;
    gt_d      = 1'b0;
    if (unord_d) begin
      lt_d = 1'b0;
    end else if (both_zero) begin
      eq_d = 1'b1;
    end else if (sign_a_q != sign_b_q) begin
      lt_d = sign_a_q;
      gt_d = !sign_a_q;
    end else if (mag_eq_q) begin
      eq_d = 1'b1;
    end else if (mag_lt_q ^ sign_a_q) begin
      // Negative operands reverse the magnitude ordering.
      lt_d = 1'b1;
    end else begin
      gt_d = 1'b1;
    end
  end

`ifdef FP_CMP_MINMAX_EN
  localparam logic [W-1:0] QNAN_C = W'(canon_qnan(EXP_W, MAN_W));

  logic [W-1:0] min_d, max_d, min_q, max_q;

  always_comb begin
    min_d = a_q;
    max_d = a_q;
    if (a_nan && b_nan) begin
      min_d = QNAN_C;
      max_d = QNAN_C;
    end else if (a_nan) begin
      min_d = b_q;
      max_d = b_q;
    end else if (b_nan) begin
      min_d = a_q;
      max_d = a_q;
    end else if (both_zero && (sign_a_q != sign_b_q)) begin
      // -0 orders below +0 for min/max even though they compare equal.
      min_d = sign_a_q ? a_q : b_q;
      max_d = sign_a_q ? b_q : a_q;
    end else if (lt_d) begin
      min_d = a_q;
      max_d = b_q;
    end else if (gt_d) begin
      min_d = b_q;
      max_d = a_q;
    end
  end

  assign min_res = min_q;
  assign max_res = max_q;
`endif

  logic lt_q, eq_q, gt_q, unord_q, invalid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      lt_q       <= 1'b0;
      eq_q       <= 1'b0;
      gt_q       <= 1'b0;
      unord_q    <= 1'b0;
      invalid_q  <= 1'b0;
`ifdef FP_CMP_MINMAX_EN
      min_q      <= '0;
      max_q      <= '0;
`endif
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      lt_q       <= lt_d;
      eq_q       <= eq_d;
      gt_q       <= gt_d;
      unord_q    <= unord_d;
      invalid_q  <= invalid_d;
`ifdef FP_CMP_MINMAX_EN
      min_q      <= min_d;
      max_q      <= max_d;
`endif
    end
  end

  assign lt      = lt_q;
  assign eq      = eq_q;
  assign gt      = gt_q;
  assign unord   = unord_q;
  assign invalid = invalid_q;

endmodule
